mmu_tlb: RTL and testbench

//  Parametrised successor to the two-level page-walking MMU: translates 32-bit virtual to physical addresses

---
 rtl/mmu_tlb_if.sv | 32 +++
 rtl/mmu_tlb.sv | 167 ++++++++++++++++
 tb/tb_mmu_tlb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_tlb_if.sv
// CPU-side request port, memory bus and page-table base controls of the TLB-based MMU.
interface mmu_tlb_if #(
  parameter int DATA_WIDTH = 256
);
  logic [31:0]           mmu_base_i;
  logic                  mmu_we;
  logic                  tlb_flush_i;
  logic [31:0]           mmu_base_o;
  logic [31:0]           v_addr_i;
  logic [DATA_WIDTH-1:0] v_data_i;
  logic [DATA_WIDTH-1:0] v_data_o;
  logic                  v_we_i;
  logic                  v_rd_i;
  logic                  v_ack_o;
  logic                  page_fault;
  logic [31:0]           addr_o;
  logic [DATA_WIDTH-1:0] data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  we_o;
  logic                  rd_o;
  logic                  ack_i;

  modport slave (
    input  mmu_base_i, mmu_we, tlb_flush_i, v_addr_i, v_data_i, v_we_i, v_rd_i, data_i, ack_i,
    output mmu_base_o, v_data_o, v_ack_o, page_fault, addr_o, data_o, we_o, rd_o
  );

  modport master (
    output mmu_base_i, mmu_we, tlb_flush_i, v_addr_i, v_data_i, v_we_i, v_rd_i, data_i, ack_i,
    input  mmu_base_o, v_data_o, v_ack_o, page_fault, addr_o, data_o, we_o, rd_o
  );
endinterface

// File: rtl/mmu_tlb.sv
// Fully-associative TLB with a two-level hardware page walker and per-page write protection.
// Hit: bus op the cycle after the request edge, v_ack_o the cycle after ack_i; a miss adds two PTE reads.
module mmu_tlb #(
  parameter int DATA_WIDTH  = 256,
  parameter int TLB_ENTRIES = 8
) (
  input logic       clk,
  input logic       rst,
  mmu_tlb_if.slave  mif
);
  localparam int PW = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  typedef enum logic [2:0] {IDLE, WALK1, WALK2, ACCESS, RESP, RELEASE} state_t;
  state_t state, state_nxt;

  logic [31:0]            base;
  logic [TLB_ENTRIES-1:0] tlb_vld;
  logic [TLB_ENTRIES-1:0] tlb_w;
  logic [19:0]            tlb_vpn [TLB_ENTRIES];
  logic [19:0]            tlb_ppn [TLB_ENTRIES];
  logic [PW-1:0]          rptr;
  logic [31:0]            req_va;
  logic [31:0]            pte_addr;
  logic                   req_we;
  logic                   fault;
  logic                   fill_ok;
  logic [19:0]            cur_ppn;
  logic                   cur_w;
  logic [DATA_WIDTH-1:0]  rdata;

  logic        req, flush, perm_fault, fill;
  logic        hit, hit_w;
  logic [19:0] hit_ppn;
  logic [31:0] pte;
  logic        rd, we;
  logic [31:0] addr;

  assign req        = mif.v_we_i | mif.v_rd_i;
  assign flush      = mif.mmu_we | mif.tlb_flush_i;
  assign pte        = mif.data_i[31:0];
  assign perm_fault = req_we & ~cur_w;
  // A walk whose table was rebased or flushed under it still answers, but never installs.
  assign fill       = (state == WALK2) & mif.ack_i & pte[0] & fill_ok & ~flush;

  always_comb begin
    hit     = 1'b0;
    hit_ppn = '0;
    hit_w   = 1'b0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (tlb_vld[i] && tlb_vpn[i] == mif.v_addr_i[31:12]) begin
        hit     = 1'b1;
        hit_ppn = tlb_ppn[i];
        hit_w   = tlb_w[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd        = 1'b0;
    we        = 1'b0;
    addr      = '0;
    case (state)
      IDLE:    if (req) state_nxt = hit ? ACCESS : WALK1;
      WALK1: begin
        rd   = 1'b1;
        addr = pte_addr;
        if (mif.ack_i) state_nxt = pte[0] ? WALK2 : RESP;
      end
      WALK2: begin
        rd   = 1'b1;
        addr = pte_addr;
        if (mif.ack_i) state_nxt = pte[0] ? ACCESS : RESP;
      end
      ACCESS: begin
        if (perm_fault) begin
          state_nxt = RESP;
        end else begin
          rd   = ~req_we;
          we   = req_we;
          addr = {cur_ppn, req_va[11:0]};
          if (mif.ack_i) state_nxt = RESP;
        end
      end
      RESP:    state_nxt = RELEASE;
      RELEASE: if (!req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base     <= '0;
      tlb_vld  <= '0;
      rptr     <= '0;
      req_va   <= '0;
      req_we   <= 1'b0;
      pte_addr <= '0;
      fault    <= 1'b0;
      fill_ok  <= 1'b0;
      cur_ppn  <= '0;
      cur_w    <= 1'b0;
      rdata    <= '0;
    end else begin
      if (mif.mmu_we) base <= mif.mmu_base_i & 32'hFFFF_F000;
      case (state)
        IDLE: if (req) begin
          req_va   <= mif.v_addr_i;
          req_we   <= mif.v_we_i;
          fault    <= 1'b0;
          fill_ok  <= 1'b1;
          cur_ppn  <= hit_ppn;
          cur_w    <= hit_w;
          // L1 address is fixed here so a later rebase cannot redirect this walk.
          pte_addr <= base + {20'h0, mif.v_addr_i[31:22], 2'b00};
        end
        WALK1: if (mif.ack_i) begin
          if (pte[0]) pte_addr <= {pte[31:12], 12'h000} + {20'h0, req_va[21:12], 2'b00};
          else        fault    <= 1'b1;
        end
        WALK2: if (mif.ack_i) begin
          if (pte[0]) begin
            cur_ppn <= pte[31:12];
            cur_w   <= pte[1];
          end else begin
            fault <= 1'b1;
          end
        end
        ACCESS: begin
          if (perm_fault)                 fault <= 1'b1;
          else if (mif.ack_i && !req_we)  rdata <= mif.data_i;
        end
        default: ;
      endcase
      if (fill) begin
        tlb_vld[rptr] <= 1'b1;
        rptr          <= rptr + 1'b1;
      end
      if (flush) begin
        tlb_vld <= '0;
        fill_ok <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tlb_vpn[rptr] <= req_va[31:12];
      tlb_ppn[rptr] <= pte[31:12];
      tlb_w[rptr]   <= pte[1];
    end
  end

  assign mif.rd_o       = rd;
  assign mif.we_o       = we;
  assign mif.addr_o     = addr;
  assign mif.data_o     = we ? mif.v_data_i : '0;
  assign mif.v_data_o   = rdata;
  assign mif.v_ack_o    = (state == RESP);
  assign mif.page_fault = (state == RESP) & fault;
  assign mif.mmu_base_o = base;
endmodule

// File: tb/tb_mmu_tlb.sv
// Random and directed traffic against a page-table/TLB reference model; bus and response scoreboards.
module tb_mmu_tlb;
  localparam int DW = 256;
  localparam int NE = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmu_tlb_if #(.DATA_WIDTH(DW)) mif ();
  mmu_tlb #(.DATA_WIDTH(DW), .TLB_ENTRIES(NE)) dut (.clk(clk), .rst(rst), .mif(mif));

  typedef struct { bit we; logic [31:0] addr; logic [DW-1:0] wd; } bus_t;
  typedef struct { bit fault; bit chk_data; logic [DW-1:0] rd; } resp_t;
  typedef struct { logic [19:0] vpn; logic [19:0] ppn; bit w; } tent_t;

  bus_t        bus_q[$];
  resp_t       resp_q[$];
  tent_t       tlb_q[$];     // fills in arrival order; oldest is evicted first
  logic [31:0] pt [logic [31:0]];
  logic [31:0] m_base;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rdw(input logic [31:0] a);
    return pt.exists(a) ? pt[a] : 32'h0;
  endfunction

  function automatic logic [DW-1:0] mkdata(input logic [31:0] a);
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = (a ^ 32'h5A5A_0000) * 32'h9E37_79B1 + 32'(i);
    d[31:0] = rdw(a);
    return d;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference: translate by the page-table rules and queue every bus op and the final response.
  task automatic predict(input logic [31:0] va, input bit we, input logic [DW-1:0] wd, input bit drop_fill);
    int idx = -1;
    logic [19:0] ppn;
    bit w;
    logic [31:0] a1, a2, p1, p2;
    resp_t r;
    r.fault = 1'b0; r.chk_data = 1'b0; r.rd = '0;
    foreach (tlb_q[i]) if (tlb_q[i].vpn == va[31:12]) idx = i;
    if (idx >= 0) begin
      ppn = tlb_q[idx].ppn;
      w   = tlb_q[idx].w;
    end else begin
      a1 = m_base + {20'h0, va[31:22], 2'b00};
      bus_q.push_back(bus_t'{we: 1'b0, addr: a1, wd: '0});
      p1 = rdw(a1);
      if (!p1[0]) begin r.fault = 1'b1; resp_q.push_back(r); return; end
      a2 = {p1[31:12], 12'h000} + {20'h0, va[21:12], 2'b00};
      bus_q.push_back(bus_t'{we: 1'b0, addr: a2, wd: '0});
      p2 = rdw(a2);
      if (!p2[0]) begin r.fault = 1'b1; resp_q.push_back(r); return; end
      ppn = p2[31:12];
      w   = p2[1];
      if (!drop_fill) begin
        if (tlb_q.size() == NE) void'(tlb_q.pop_front());
        tlb_q.push_back(tent_t'{vpn: va[31:12], ppn: ppn, w: w});
      end
    end
    if (we && !w) begin r.fault = 1'b1; resp_q.push_back(r); return; end
    bus_q.push_back(bus_t'{we: we, addr: {ppn, va[11:0]}, wd: wd});
    if (!we) begin r.chk_data = 1'b1; r.rd = mkdata({ppn, va[11:0]}); end
    resp_q.push_back(r);
  endtask

  task automatic set_base(input logic [31:0] b);
    mif.mmu_base_i = b; mif.mmu_we = 1'b1;
    @(negedge clk);
    mif.mmu_we = 1'b0;
    m_base = b & 32'hFFFF_F000;
    tlb_q.delete();
  endtask

  task automatic flush_tlb();
    mif.tlb_flush_i = 1'b1;
    @(negedge clk);
    mif.tlb_flush_i = 1'b0;
    tlb_q.delete();
  endtask

  task automatic do_req(input logic [31:0] va, input bit we, input logic [DW-1:0] wd, input bit mid_we);
    int n;
    logic [31:0] a2;
    predict(va, we, wd, mid_we);
    mif.v_addr_i = va; mif.v_data_i = wd; mif.v_we_i = we; mif.v_rd_i = !we;
    if (mid_we) begin
      a2 = {rdw(m_base + {20'h0, va[31:22], 2'b00})[31:12], 12'h000} + {20'h0, va[21:12], 2'b00};
      n = 0;
      do begin @(negedge clk); n++; end while (!(mif.rd_o && mif.addr_o == a2) && n < 100);
      chk("walk2_reached", mif.addr_o, a2);
      mif.mmu_base_i = m_base; mif.mmu_we = 1'b1;
      @(negedge clk);
      mif.mmu_we = 1'b0;
      tlb_q.delete();
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!mif.v_ack_o && n < 400);
    chk("ack_seen", mif.v_ack_o, 1'b1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    mif.v_we_i = 1'b0; mif.v_rd_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_v_ack_o"},    mif.v_ack_o, 0);
    chk({tag, "_page_fault"}, mif.page_fault, 0);
    chk({tag, "_rd_o"},       mif.rd_o, 0);
    chk({tag, "_we_o"},       mif.we_o, 0);
    chk({tag, "_addr_o"},     mif.addr_o, 0);
    chk({tag, "_data_o"},     mif.data_o, 0);
    chk({tag, "_v_data_o"},   mif.v_data_o, 0);
    chk({tag, "_mmu_base_o"}, mif.mmu_base_o, 0);
  endtask

  // Response monitor
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (!rst && (mif.v_ack_o || mif.page_fault)) begin
        if (resp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got ack=%0b pf=%0b want no response", mif.v_ack_o, mif.page_fault);
        end else begin
          r = resp_q.pop_front();
          chk("resp_ack", mif.v_ack_o, 1'b1);
          chk("resp_fault", mif.page_fault, r.fault);
          if (r.chk_data) chk("resp_rdata", mif.v_data_o, r.rd);
        end
      end
    end
  end

  // Memory responder and bus monitor
  initial begin
    bus_t b;
    int dly;
    mif.ack_i = 1'b0; mif.data_i = '0;
    forever begin
      @(negedge clk);
      mif.ack_i = 1'b0;
      if (!rst && (mif.rd_o || mif.we_o)) begin
        if (bus_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_bus: got rd=%0b we=%0b addr=%0h want no bus op", mif.rd_o, mif.we_o, mif.addr_o);
        end else begin
          b = bus_q.pop_front();
          chk("bus_we", mif.we_o, b.we);
          chk("bus_rd", mif.rd_o, !b.we);
          chk("bus_addr", mif.addr_o, b.addr);
          if (b.we) chk("bus_wdata", mif.data_o, b.wd);
        end
        dly = $urandom_range(0, 3);
        for (int k = 0; k < dly && !rst; k++) @(negedge clk);
        if (!rst) begin
          mif.data_i = mkdata(mif.addr_o);
          mif.ack_i  = 1'b1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] va;
    bit wr;
    rst = 1'b1;
    mif.mmu_base_i = '0; mif.mmu_we = 1'b0; mif.tlb_flush_i = 1'b0;
    mif.v_addr_i = '0; mif.v_data_i = '0; mif.v_we_i = 1'b0; mif.v_rd_i = 1'b0;
    m_base = '0;
    pt[32'h0000_0000] = 32'h0001_0001;   // L1[0] -> L2 table at 0x10000
    pt[32'h0000_0004] = 32'h0000_0000;   // L1[1] invalid
    pt[32'h0008_0000] = 32'h0001_0001;   // L1[0] for the alternate base
    pt[32'h0001_0000] = 32'h0001_0001;   // page 0 read-only
    pt[32'h0001_0004] = 32'h0001_0003;   // page 1 writable
    for (int k = 2; k < 32; k++) begin
      if (k < 10) pt[32'h0001_0000 + 32'(k*4)] = {20'h00100 + 20'(k), 12'h003};
      else        pt[32'h0001_0000 + 32'(k*4)] = {20'h00100 + 20'(k), 10'h0, 1'($urandom), 1'($urandom_range(0, 4) != 0)};
    end

    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("post_reset");

    set_base(32'h0);
    do_req(32'h0000_1004, 1'b0, '0, 1'b0);          // miss: two PTE reads then data
    do_req(32'h0000_1008, 1'b0, '0, 1'b0);          // hit: data only
    do_req(32'h0040_0000, 1'b0, '0, 1'b0);          // L1 invalid
    do_req(32'h0000_0000, 1'b1, rnd_data(), 1'b0);  // read-only page
    do_req(32'h0000_1010, 1'b1, rnd_data(), 1'b0);  // writable hit

    flush_tlb();
    for (int k = 1; k <= NE + 1; k++) do_req(32'(k) << 12, 1'b0, '0, 1'b0);
    do_req(32'h0000_1000, 1'b0, '0, 1'b0);          // evicted, walks again

    flush_tlb();
    do_req(32'h0000_2020, 1'b0, '0, 1'b1);          // rebase during WALK2
    do_req(32'h0000_2024, 1'b0, '0, 1'b0);          // fill was dropped: walks again
    do_req(32'h0000_2028, 1'b1, rnd_data(), 1'b0);  // now a hit

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 15) == 0) flush_tlb();
      va = {10'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), 12'($urandom)};
      wr = 1'($urandom);
      do_req(va, wr, wr ? rnd_data() : '0, 1'b0);
    end

    set_base(32'h0008_0ABC);
    chk("base_masked", mif.mmu_base_o, 32'h0008_0000);
    do_req(32'h0000_1004, 1'b0, '0, 1'b0);          // walks through the new base

    predict(32'h0000_1008, 1'b0, '0, 1'b0);
    mif.v_addr_i = 32'h0000_1008; mif.v_rd_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(mif.rd_o && mif.addr_o == 32'h0001_0008) && n < 50);
    chk("rst_in_access", mif.addr_o, 32'h0001_0008);
    rst = 1'b1;
    #1;
    chk_quiet("mid_reset");
    mif.v_rd_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus_q.delete(); resp_q.delete(); tlb_q.delete(); m_base = '0;
    chk_quiet("after_mid_reset");
    do_req(32'h0000_1004, 1'b0, '0, 1'b0);          // TLB empty, base 0 after reset

    repeat (10) @(negedge clk);
    chk("bus_q_drained", 32'(bus_q.size()), 0);
    chk("resp_q_drained", 32'(resp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
